// File: rtl/ram_stream_pkg.sv
// Shared types for the RAM stream reader: FSM states and skid sizing.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int CNT_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry registered FIFO absorbing RAM read data under stream backpressure.
module ram_rd_skid
    import ram_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic [CNT_WIDTH-1:0] count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             full;

    assign full = count == CNT_WIDTH'(SKID_DEPTH);
    assign dout = head;

    // head is always the oldest word; tail only holds data when full
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == '0) head <= din;
                    else             tail <= din;
                    count <= count + CNT_WIDTH'(1);
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - CNT_WIDTH'(1);
                end
                2'b11: begin
                    if (full) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read initiator: RAM port to valid/ready stream with skid buffering.
// Optional out_last output enabled by RAM_STREAM_READER_LAST_EN.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
`ifdef RAM_STREAM_READER_LAST_EN
    output logic                  out_last,
`endif
    output logic                  busy
);

`ifdef RAM_STREAM_READER_LAST_EN
    localparam int SKID_WIDTH = DATA_WIDTH + 1;
`else
    localparam int SKID_WIDTH = DATA_WIDTH;
`endif

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] held_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  inflight;
    logic [CNT_WIDTH-1:0]  entries;
    logic [2:0]            occupancy;
    logic                  pop;
    logic                  credit;
    logic                  issue;
    logic                  accept;
    logic [SKID_WIDTH-1:0] skid_in;
    logic [SKID_WIDTH-1:0] skid_out;

    assign pop       = out_valid && out_ready;
    assign out_valid = entries != '0;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = cmd_valid && cmd_ready && (cmd_len != '0);

    // Words that will be held next cycle if nothing new is issued now
    assign occupancy = 3'(entries) + 3'(inflight) - 3'(pop);
    assign credit    = occupancy < 3'(SKID_DEPTH);

    assign ram_addr  = issue ? next_addr : held_addr;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = READ;
            end
            READ: begin
                if (credit) begin
                    issue = 1'b1;
                    if (remaining == LEN_WIDTH'(1))
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (occupancy == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            inflight  <= 1'b0;
            held_addr <= '0;
            next_addr <= '0;
            remaining <= '0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if (accept) begin
                next_addr <= cmd_addr;
                remaining <= cmd_len;
            end else if (issue) begin
                held_addr <= next_addr;
                next_addr <= next_addr + ADDR_WIDTH'(1);
                remaining <= remaining - LEN_WIDTH'(1);
            end
        end
    end

`ifdef RAM_STREAM_READER_LAST_EN
    logic inflight_last;

    always_ff @(posedge clk) begin
        if (rst) inflight_last <= 1'b0;
        else     inflight_last <= issue && (remaining == LEN_WIDTH'(1));
    end

    assign skid_in  = {inflight_last, ram_dout};
    assign out_last = skid_out[DATA_WIDTH];
`else
    assign skid_in  = ram_dout;
`endif

    assign out_data = skid_out[DATA_WIDTH-1:0];

    ram_rd_skid #(
        .WIDTH (SKID_WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (skid_in),
        .dout  (skid_out),
        .count (entries)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized bench for ram_stream_reader against a queue-based burst model.
module tb_ram_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_addr = '0;
    logic [10:0] cmd_len = '0;
    logic [9:0]  ram_addr;
    logic [31:0] ram_dout = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;
`ifdef RAM_STREAM_READER_LAST_EN
    logic        out_last;
`endif

    logic [31:0] mem [1024];
    logic [31:0] exp_q [$];
    logic        last_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    // RAM with registered 1-cycle read, write port unused here
    always @(posedge clk) ram_dout <= mem[ram_addr];

    ram_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef RAM_STREAM_READER_LAST_EN
        .out_last  (out_last),
`endif
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pick(input int mode, input int t);
        logic [5:0] pat;
        pat = 6'b101001;
        case (mode)
            0:       return 1'b1;
            1:       return pat[(t - 1) % 6];
            2:       return 1'($urandom % 2);
            default: return t >= 12;
        endcase
    endfunction

    // One burst: model expectations, command handshake, stream check.
    task automatic run_burst(input int a, input int len, input int mode,
                             input int abort);
        int t;
        int n;
        int first;
        int limit;
        logic [31:0] ew;
        logic        el;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(mem[(a + i) % 1024]);
            last_q.push_back(i == len - 1);
        end
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = 10'(a);
        cmd_len   = 11'(len);
        out_ready = pick(mode, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (len == 0) begin
            chk("len0_busy", busy, 0);
            chk("len0_valid", out_valid, 0);
            chk("len0_ready", cmd_ready, 1);
            return;
        end
        t = 1;
        n = 0;
        first = -1;
        limit = 4 * len + 60;
        while (n < len && t < limit) begin
            out_ready = pick(mode, t);
            #1;
            if (t == 1) chk("first_addr", ram_addr, 64'(a));
            if (mode == 3 && len >= 2 && t >= 4 && t < 12)
                chk("stall_addr", ram_addr, 64'((a + 1) % 1024));
            if (mode == 3 && t >= 12)
                chk("no_bubble", out_valid, 1);
            if (out_valid && first < 0) first = t;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    ew = exp_q.pop_front();
                    el = last_q.pop_front();
                    chk("data", out_data, ew);
`ifdef RAM_STREAM_READER_LAST_EN
                    chk("last", out_last, el);
`else
                    if (el) chk("final_busy", busy, 1);
`endif
                end
                n++;
                if (n == abort) begin
                    @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_valid", out_valid, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_ready", cmd_ready, 1);
                    exp_q.delete();
                    last_q.delete();
                    return;
                end
            end
            @(negedge clk);
            t++;
        end
        chk("burst_words", n, len);
        if (mode == 0) begin
            chk("first_latency", first, 3);
            chk("done_latency", t, len + 3);
            chk("done_ready", cmd_ready, 1);
        end
        out_ready = 1'b1;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        #1;
        chk("idle_ready", cmd_ready, 1);
        chk("idle_valid", out_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_ram_addr", ram_addr, 0);
        chk("reset_busy", busy, 0);

        run_burst(32'h010, 4, 0, -1);
        run_burst(32'h3FE, 4, 0, -1);
        run_burst(32'h020, 8, 1, -1);
        run_burst(32'h030, 0, 0, -1);
        run_burst(32'h040, 2, 0, -1);
        run_burst(32'h050, 8, 3, -1);

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        run_burst(32'h100, 16, 0, 3);
        run_burst(32'h200, 6, 0, -1);
        run_burst(32'h123, 1, 1, -1);
        run_burst(32'h321, 5, 1, -1);
        run_burst(32'h0F0, 5, 3, -1);

        for (int k = 0; k < 14; k++) begin
            run_burst(int'($urandom % 1024), int'($urandom_range(0, 20)),
                      int'($urandom % 4), -1);
        end
        run_burst(int'($urandom % 1024), 1024, 2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
